// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage program counter and I-cache request controller.
//
// Holds the architectural fetch PC and selects the next one from the PC+4
// adder or an execute-stage redirect. The PC is frozen while the I-cache
// request is outstanding. A redirect that arrives during a miss is parked
// in redir_pc and applied once the outstanding request completes.
//
// Optional feature: define PC_MISS_CNT_EN to add the MissCycles output.
// This is a saturating count of cycles in which the request is pending
// but the cache is not ready.

module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PCPlus4,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PCSrcE,
  input  logic            StallF,
  input  logic            IC_Ready,
  output logic [XLEN-1:0] PC,
  output logic            IC_Req,
  output logic            FetchValid
`ifdef PC_MISS_CNT_EN
  ,
  output logic [31:0]     MissCycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clears the two byte-offset bits so that every PC stays word-aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  state_t          state, state_next;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] redir_pc, redir_next;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] plus4_aligned;

  assign target_aligned = PCTargetE & ALIGN_MASK;
  assign plus4_aligned  = PCPlus4   & ALIGN_MASK;

  // State, PC and parked-redirect registers; reset takes effect immediately.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      PC       <= RESET_PC;
      redir_pc <= '0;
    end else begin
      state    <= state_next;
      PC       <= pc_next;
      redir_pc <= redir_next;
    end
  end

  // Next-state, next-PC and request/accept outputs.
  // NOTE: every signal written here is given a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pc_next    = PC;
    redir_next = redir_pc;
    IC_Req     = 1'b0;
    FetchValid = 1'b0;

    case (state)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        IC_Req     = 1'b1;
        FetchValid = IC_Ready & ~StallF & ~PCSrcE;
        if (IC_Ready) begin
          // A redirect overrides a hazard stall. The stalled PC holds.
          if (PCSrcE)       pc_next = target_aligned;
          else if (!StallF) pc_next = plus4_aligned;
        end else if (PCSrcE) begin
          // The miss cannot be aborted. Park the target until the fill completes.
          redir_next = target_aligned;
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        // The drained instruction belongs to the wrong path, so FetchValid stays 0.
        IC_Req = 1'b1;
        if (PCSrcE) redir_next = target_aligned;
        if (IC_Ready) begin
          pc_next    = PCSrcE ? target_aligned : redir_pc;
          state_next = FETCH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef PC_MISS_CNT_EN
  logic [31:0] miss_cnt;

  // Saturating count of cycles in which the request waits on the cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
    end else if (IC_Req && !IC_Ready && (miss_cnt != 32'hFFFF_FFFF)) begin
      miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign MissCycles = miss_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios followed by random stimulus.
// Every cycle is compared against a transaction-level model of the fetch PC.
// In that model, a redirect taken during a miss waits in a queue of pending
// targets. The newest pending target wins when the fill arrives.

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCPlus4;
  logic [31:0] PCTargetE;
  logic        PCSrcE;
  logic        StallF;
  logic        IC_Ready;
  logic [31:0] PC;
  logic        IC_Req;
  logic        FetchValid;
`ifdef PC_MISS_CNT_EN
  logic [31:0] MissCycles;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_running;     // past the single post-reset idle cycle
  logic [31:0] pend_q[$];     // redirect targets waiting for a miss to finish
  logic [31:0] m_miss;

  always #5 clk = ~clk;

  // The PC+4 adder lives outside the block.
  assign PCPlus4 = PC + 32'd4;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCPlus4    (PCPlus4),
    .PCTargetE  (PCTargetE),
    .PCSrcE     (PCSrcE),
    .StallF     (StallF),
    .IC_Ready   (IC_Ready),
    .PC         (PC),
    .IC_Req     (IC_Req),
    .FetchValid (FetchValid)
`ifdef PC_MISS_CNT_EN
    ,
    .MissCycles (MissCycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_running = 1'b0;
    pend_q.delete();
    m_miss    = 32'h0;
  endtask

  // One clock cycle of stimulus. The inputs are driven on the falling edge.
  // The outputs are compared 1 time unit later, well away from the rising
  // edge. The model then advances to the state that follows the next
  // rising edge.
  task automatic step(input bit src, input logic [31:0] tgt, input bit stall,
                      input bit ready, input string tag);
    bit          exp_req;
    bit          exp_fv;
    logic [31:0] tgt_w;
    @(negedge clk);
    PCSrcE    = src;
    PCTargetE = tgt;
    StallF    = stall;
    IC_Ready  = ready;
    #1;
    tgt_w   = tgt & 32'hFFFF_FFFC;
    exp_req = m_running;
    exp_fv  = m_running && (pend_q.size() == 0) && ready && !stall && !src;
    check({tag, ".pc"},  PC,                 m_pc);
    check({tag, ".req"}, {31'b0, IC_Req},     {31'b0, exp_req});
    check({tag, ".fv"},  {31'b0, FetchValid}, {31'b0, exp_fv});
`ifdef PC_MISS_CNT_EN
    check({tag, ".miss"}, MissCycles, m_miss);
`endif
    if (m_running && !ready && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
    if (!m_running) begin
      m_running = 1'b1;
    end else if (pend_q.size() != 0) begin
      if (src) pend_q.push_back(tgt_w);
      if (ready) begin
        m_pc = pend_q[$];
        pend_q.delete();
      end
    end else if (ready) begin
      if (src)         m_pc = tgt_w;
      else if (!stall) m_pc = m_pc + 32'd4;
    end else if (src) begin
      pend_q.push_back(tgt_w);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;
    StallF    = 1'b0;
    IC_Ready  = 1'b1;
    model_reset();

    // Reset state.
    #3;
    check("rst.pc",  PC,                 32'h0);
    check("rst.req", {31'b0, IC_Req},     32'h0);
    check("rst.fv",  {31'b0, FetchValid}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // One idle cycle, then a zero-wait hit stream: 0, 4, 8.
    step(0, 0, 0, 1, "idle");
    step(0, 0, 0, 1, "hit0");
    step(0, 0, 0, 1, "hit4");
    check("hit.pc8", PC, 32'h4);   // PC still 0x4 here; it moves to 0x8 at the next edge

    // Three-cycle miss at 0x8, then a fill.
    step(0, 0, 0, 0, "miss1");
    step(0, 0, 0, 0, "miss2");
    step(0, 0, 0, 0, "miss3");
    step(0, 0, 0, 1, "fill8");
    step(0, 0, 0, 1, "hitC");
    check("miss.pc", PC, 32'hC);

    // Stall holds 0x10. A redirect to 0x43 overrides the stall and aligns to 0x40.
    step(0, 0, 1, 1, "stall1");
    step(0, 0, 1, 1, "stall2");
    step(1, 32'h43, 1, 1, "stall_redir");
    step(0, 0, 0, 0, "at40");
    check("stall_redir.pc", PC, 32'h40);

    // Redirect during a miss, overwritten by a later one. Stall is ignored in drain.
    step(1, 32'h100, 0, 0, "drain_a");
    step(0, 0, 0, 0, "drain_b");
    step(1, 32'h200, 0, 0, "drain_c");
    step(0, 0, 1, 1, "drain_fill");
    step(0, 0, 0, 1, "at200");
    check("drain.pc", PC, 32'h200);

    // A redirect that coincides with the fill in drain goes straight to the PC.
    step(1, 32'h300, 0, 0, "co_a");
    step(1, 32'h404, 0, 1, "co_fill");
    step(0, 0, 0, 1, "at404");

    // Wrap from 0xFFFF_FFFC to 0.
    step(1, 32'hFFFF_FFFC, 0, 1, "wrap_redir");
    step(0, 0, 0, 1, "wrap_top");
    step(0, 0, 0, 1, "wrap_zero");

    // Asynchronous reset while draining.
    step(0, 0, 0, 0, "pre_rst_miss");
    step(1, 32'h500, 0, 0, "pre_rst_drain");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.pc",  PC,                 32'h0);
    check("arst.req", {31'b0, IC_Req},     32'h0);
    check("arst.fv",  {31'b0, FetchValid}, 32'h0);
`ifdef PC_MISS_CNT_EN
    check("arst.miss", MissCycles, 32'h0);
`endif
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 0, 0, 1, "post_idle");
    step(0, 0, 0, 1, "post_hit0");
    step(0, 0, 0, 1, "post_hit4");

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 15,
           $urandom(),
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 70,
           "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
